// File: rtl/dccm_port_arb.sv
// ============================================================================
// dccm_port_arb
//
// Shares the single DCCM port between the core LSU (requester 0) and a
// DMA/loader master (requester 1). It also peels off the two MMIO store
// addresses so they never reach the DCCM array:
//   - a store to CONSOLE_ADDR becomes a one-cycle character strobe
//   - a store to FINISH_ADDR sets a sticky end-of-test flag
//
// The LSU normally wins. A DMA request that has been refused STARVE_LIMIT
// cycles in a row is promoted over the LSU for one grant.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   lsu_req/we/addr/wdata/wbe  LSU request (addr is a word-aligned byte address)
//   lsu_gnt                  request accepted this cycle (combinational)
//   lsu_rvalid, lsu_rdata    load return, one cycle after the grant
//   dma_*                    same set of signals for the DMA master
//   dccm_en/wen/addr/wdata/wbe  DCCM macro request (all zero when idle)
//   dccm_rdata               DCCM read data, one cycle after dccm_en
//   console_valid/char       one-cycle console character strobe
//   finish                   sticky end-of-test flag
//   dma_starved              DMA promoted over the LSU this cycle (debug)
// ============================================================================
module dccm_port_arb #(
    parameter int              XLEN         = 32,
    parameter int              STARVE_LIMIT = 4,
    parameter logic [XLEN-1:0] CONSOLE_ADDR = 'h0020_0000,
    parameter logic [XLEN-1:0] FINISH_ADDR  = 'h1000_0000
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [XLEN-1:0]     lsu_addr,
    input  logic [XLEN-1:0]     lsu_wdata,
    input  logic [XLEN/8-1:0]   lsu_wbe,
    output logic                lsu_gnt,
    output logic                lsu_rvalid,
    output logic [XLEN-1:0]     lsu_rdata,

    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [XLEN-1:0]     dma_addr,
    input  logic [XLEN-1:0]     dma_wdata,
    input  logic [XLEN/8-1:0]   dma_wbe,
    output logic                dma_gnt,
    output logic                dma_rvalid,
    output logic [XLEN-1:0]     dma_rdata,

    output logic                dccm_en,
    output logic                dccm_wen,
    output logic [XLEN-1:0]     dccm_addr,
    output logic [XLEN-1:0]     dccm_wdata,
    output logic [XLEN/8-1:0]   dccm_wbe,
    input  logic [XLEN-1:0]     dccm_rdata,

    output logic                console_valid,
    output logic [7:0]          console_char,
    output logic                finish,
    output logic                dma_starved
);

    localparam int         BE_W  = XLEN / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Who is owed read data in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LSU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    logic [3:0]      starve_cnt;
    owner_t          rd_owner;
    owner_t          rd_owner_next;
    logic            rd_mmio;
    logic            rd_mmio_next;

    logic            sel_dma;
    logic            any_gnt;
    logic            win_we;
    logic [XLEN-1:0] win_addr;
    logic [XLEN-1:0] win_wdata;
    logic [BE_W-1:0] win_wbe;
    logic            win_console;
    logic            win_finish;
    logic            win_mmio;
    logic            console_store;
    logic            finish_store;

    // Arbitration. The DMA takes the port when the LSU is idle, or when it
    // has waited long enough to be promoted over a requesting LSU.
    always_comb begin
        dma_starved = dma_req && (starve_cnt >= LIMIT);
        sel_dma     = dma_req && (dma_starved || !lsu_req);
        any_gnt     = lsu_req || dma_req;
        lsu_gnt     = lsu_req && !sel_dma;
        dma_gnt     = sel_dma;
    end

    // Mux the winner's request and decode the MMIO addresses.
    always_comb begin
        win_we        = sel_dma ? dma_we    : lsu_we;
        win_addr      = sel_dma ? dma_addr  : lsu_addr;
        win_wdata     = sel_dma ? dma_wdata : lsu_wdata;
        win_wbe       = sel_dma ? dma_wbe   : lsu_wbe;
        win_console   = any_gnt && (win_addr == CONSOLE_ADDR);
        win_finish    = any_gnt && (win_addr == FINISH_ADDR);
        win_mmio      = win_console || win_finish;
        console_store = win_console && win_we;
        finish_store  = win_finish && win_we;
    end

    // DCCM request. Address, data and byte enables are zeroed whenever the
    // array is not being accessed so the macro pins stay quiet on idle and
    // MMIO cycles.
    always_comb begin
        dccm_en    = any_gnt && !win_mmio;
        dccm_wen   = dccm_en && win_we;
        dccm_addr  = dccm_en ? win_addr  : '0;
        dccm_wdata = dccm_en ? win_wdata : '0;
        dccm_wbe   = dccm_en ? win_wbe   : '0;
    end

    // Starvation counter: counts consecutive refused DMA cycles, saturating
    // so a very long wait cannot wrap back below the promotion threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (dma_req && !dma_gnt) begin
            if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    // A granted load (DCCM or MMIO) claims next cycle's read return.
    always_comb begin
        rd_owner_next = OWN_NONE;
        rd_mmio_next  = 1'b0;
        if (any_gnt && !win_we) begin
            rd_owner_next = sel_dma ? OWN_DMA : OWN_LSU;
            rd_mmio_next  = win_mmio;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
            rd_mmio  <= 1'b0;
        end else begin
            rd_owner <= rd_owner_next;
            rd_mmio  <= rd_mmio_next;
        end
    end

    // Read return. The DCCM data only exists in the return cycle, so rdata
    // is steered from the macro output by the registered owner; both are
    // zero out of reset because the owner resets to NONE.
    always_comb begin
        lsu_rvalid = (rd_owner == OWN_LSU);
        dma_rvalid = (rd_owner == OWN_DMA);
        lsu_rdata  = (lsu_rvalid && !rd_mmio) ? dccm_rdata : '0;
        dma_rdata  = (dma_rvalid && !rd_mmio) ? dccm_rdata : '0;
    end

    // MMIO side effects. console_valid is rewritten every cycle, so it is
    // high for exactly one cycle per console store; finish only ever sets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            console_valid <= 1'b0;
            console_char  <= 8'h00;
            finish        <= 1'b0;
        end else begin
            console_valid <= console_store;
            if (console_store) begin
                console_char <= win_wdata[7:0];
            end
            if (finish_store) begin
                finish <= 1'b1;
            end
        end
    end

    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
        !(lsu_gnt && dma_gnt));
    a_lsu_gnt_req : assert property (@(posedge clk) disable iff (rst)
        lsu_gnt |-> lsu_req);
    a_dma_gnt_req : assert property (@(posedge clk) disable iff (rst)
        dma_gnt |-> dma_req);

endmodule

// File: doc/dccm_port_arb.md
Name: dccm_port_arb

Overview:
- Arbitrates the single DCCM port between the core LSU (requester 0) and a DMA/loader master (requester 1).
- Decodes the two MMIO store addresses, console and finish, so those writes never reach the DCCM array. Console writes become a character strobe; finish writes set a sticky flag.
- Sits between the EXU LSU and the DCCM macro inside core_top.

Parameters:
- XLEN, 32, data/address width.
- STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA is promoted over the LSU (legal range 1..15).
- CONSOLE_ADDR, 32'h00200000, MMIO console byte address.
- FINISH_ADDR, 32'h10000000, MMIO end-of-test address.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- lsu_req  in  1  LSU access request
- lsu_we  in  1  1=store, 0=load
- lsu_addr  in  XLEN  word-aligned byte address
- lsu_wdata  in  XLEN  store data
- lsu_wbe  in  XLEN/8  store byte enables
- lsu_gnt  out  1  request accepted this cycle (combinational)
- lsu_rvalid  out  1  load data valid (one cycle after grant)
- lsu_rdata  out  XLEN  load data
- dma_req, dma_we, dma_addr, dma_wdata, dma_wbe, dma_gnt, dma_rvalid, dma_rdata: same directions, widths and meanings as the lsu_ ports, for the DMA master
- dccm_en  out  1  DCCM access enable
- dccm_wen  out  1  DCCM write enable
- dccm_addr  out  XLEN  DCCM address
- dccm_wdata  out  XLEN  DCCM write data
- dccm_wbe  out  XLEN/8  DCCM byte enables
- dccm_rdata  in  XLEN  DCCM read data (synchronous, one-cycle latency)
- console_valid  out  1  one-cycle character strobe
- console_char  out  8  character (wdata[7:0] of the console store)
- finish  out  1  sticky end-of-test flag
- dma_starved  out  1  DMA promoted this cycle (debug)

Behaviour:
- Reset values: all registered outputs 0 (lsu_rvalid, dma_rvalid, both rdata, console_valid, console_char, finish); starve_cnt=0; read-owner register=NONE.
- Combinational outputs with no requests: gnt=0, dccm_en=0, dccm_wen=0, dccm_addr/wdata/wbe=0.
- Arbitration, evaluated every cycle:
  - Winner is the LSU, unless dma_req=1 and starve_cnt>=STARVE_LIMIT; then the DMA wins and dma_starved=1.
  - Only one gnt per cycle. A gnt is never asserted without its req.
  - Grant is combinational in the request cycle; the requester holds nothing after gnt.
- Starvation counter:
  - dma_req & ~dma_gnt: increment, saturating at 15.
  - dma_gnt or ~dma_req: clear to 0.
- Address decode of the granted request:
  - DCCM: dccm_en=1, dccm_wen=we; addr/wdata/wbe forwarded from the winner.
  - Store to CONSOLE_ADDR: dccm_en=0. Next cycle console_valid=1 and console_char=wdata[7:0]; held for exactly one cycle.
  - Store to FINISH_ADDR: dccm_en=0. finish=1 from the next cycle until rst.
  - Load from either MMIO address: dccm_en=0; rvalid next cycle with rdata=0.
- Read return:
  - A granted load registers owner (LSU/DMA) and an is_mmio flag.
  - Next cycle, the owner's rvalid=1 and rdata=(is_mmio ? 0 : dccm_rdata).
  - The non-owner's rvalid and rdata are 0.
  - A new grant in that same cycle is allowed, giving back-to-back throughput of 1/cycle.
- Stores produce no rvalid.
- The LSU may change its request every cycle. An ungranted DMA request must hold stable until granted.
- Reset mid-operation: a pending rvalid is dropped; finish and starve_cnt clear.
- Simultaneous console store by the LSU and finish store by the DMA: only the winner takes effect; the loser is granted later in normal order.

Test Plan:
- Single LSU store, addr 0x100, wdata 0xDEADBEEF, wbe 0xF → same cycle lsu_gnt=1, dccm_en=1, dccm_wen=1, dccm_addr=0x100; no rvalid.
- LSU load, addr 0x100, dccm_rdata=0xDEADBEEF → lsu_rvalid=1 and lsu_rdata=0xDEADBEEF exactly one cycle later; dma_rvalid=0.
- LSU and DMA request continuously, STARVE_LIMIT=4 → LSU granted cycles 0-3, DMA granted cycle 4 with dma_starved=1, LSU granted cycle 5, DMA again at cycle 9.
- LSU store to 0x00200000 with wdata 0x41 → dccm_en=0; next cycle console_valid=1 and console_char=0x41 for one cycle only.
- DMA store to 0x10000000 → finish=1 the following cycle and stays 1; rst asserted asynchronously → finish=0 immediately.
- LSU load granted, rst pulsed before the return cycle → no rvalid after reset release; starve_cnt=0.
